cmd_mem: RTL

Memory-side responder for the processor's command-fetch interface. It stores commands as MEM_TO_CMD parallel banks of MEM_WIDTH-bit words and answers each `instr_ptr` with the full CMD_WIDTH-bit command on `cmd_read`. It also contains the host-side loader: a word-serial write stream with a valid/ready handshake, packed into the banks by a small load FSM. It sits between the host register bus and one processor core.

---
 rtl/cmd_mem_pkg.sv | 16 +
 rtl/cmd_mem_if.sv | 37 +++
 rtl/cmd_mem_bank.sv | 37 +++
 rtl/cmd_mem.sv | 124 ++++++++++++
 4 files changed

// File: rtl/cmd_mem_pkg.sv
// cmd_mem_pkg: loader state encoding and bank-select width helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cmd_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_e;

  function automatic int unsigned sel_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/cmd_mem_if.sv
// cmd_mem_if: processor fetch port plus host load stream of cmd_mem.
// Latency: n/a (wiring only).
// Backpressure: wr_valid/wr_ready handshake on the load stream.
interface cmd_mem_if
  import cmd_mem_pkg::*;
#(
  parameter int CMD_ADDR_WIDTH = 8,
  parameter int MEM_WIDTH      = 32,
  parameter int MEM_TO_CMD     = 4
);
  localparam int CMD_WIDTH = MEM_WIDTH * MEM_TO_CMD;
  localparam int SEL_W     = sel_width(MEM_TO_CMD);
  localparam int WADDR_W   = CMD_ADDR_WIDTH + SEL_W;

  logic [CMD_ADDR_WIDTH-1:0] instr_ptr;
  logic [CMD_WIDTH-1:0]      cmd_read;
  logic                      load_start;
  logic [WADDR_W-1:0]        load_base;
  logic [WADDR_W:0]          load_len;
  logic                      load_abort;
  logic [MEM_WIDTH-1:0]      wr_data;
  logic                      wr_valid;
  logic                      wr_ready;
  logic                      load_busy;
  logic                      load_done;

  modport master (
    output instr_ptr, load_start, load_base, load_len, load_abort, wr_data, wr_valid,
    input  cmd_read, wr_ready, load_busy, load_done
  );

  modport slave (
    input  instr_ptr, load_start, load_base, load_len, load_abort, wr_data, wr_valid,
    output cmd_read, wr_ready, load_busy, load_done
  );

endinterface

// File: rtl/cmd_mem_bank.sv
// cmd_mem_bank: simple dual-port RAM, one write port, registered read-first read port.
// Latency: 1 cycle read; a same-cycle write to the read row returns the old word.
// Backpressure: none, both ports accept every cycle.
module cmd_mem_bank #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  // Storage is deliberately unreset so it maps onto a RAM macro.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cmd_mem.sv
// cmd_mem: command store of MEM_TO_CMD word banks plus word-serial host loader FSM.
// Latency: cmd_read 1 cycle after instr_ptr (2 with CMD_MEM_OUTREG_EN defined).
// Backpressure: wr_ready high only in LOAD; the read path never stalls.
module cmd_mem
  import cmd_mem_pkg::*;
#(
  parameter int CMD_ADDR_WIDTH = 8,
  parameter int MEM_WIDTH      = 32,
  parameter int MEM_TO_CMD     = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  cmd_mem_if.slave bus
);

  localparam int CMD_WIDTH = MEM_WIDTH * MEM_TO_CMD;
  localparam int SEL_W     = sel_width(MEM_TO_CMD);
  localparam int WADDR_W   = CMD_ADDR_WIDTH + SEL_W;

  load_state_e          state_q;
  logic [WADDR_W-1:0]   addr_q;
  logic [WADDR_W:0]     rem_q;
  logic                 wr_ready_q;
  logic                 load_busy_q;
  logic                 load_done_q;
  logic                 accept;
  logic [SEL_W-1:0]     wsel;
  logic [CMD_ADDR_WIDTH-1:0] wrow;
  logic [CMD_WIDTH-1:0] rd_cat;

  // Abort beats a coincident handshake: that word is dropped.
  assign accept = (state_q == LOAD) && wr_ready_q && bus.wr_valid && !bus.load_abort;
  assign wsel   = addr_q[SEL_W-1:0];
  assign wrow   = addr_q[WADDR_W-1:SEL_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      wr_ready_q  <= 1'b0;
      load_busy_q <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.load_start) begin
            addr_q <= bus.load_base;
            rem_q  <= bus.load_len;
            if (bus.load_len != '0) begin
              state_q     <= LOAD;
              wr_ready_q  <= 1'b1;
              load_busy_q <= 1'b1;
            end else begin
              state_q     <= DONE;
              load_done_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (bus.load_abort) begin
            state_q     <= IDLE;
            wr_ready_q  <= 1'b0;
            load_busy_q <= 1'b0;
          end else if (accept) begin
            addr_q <= addr_q + WADDR_W'(1);
            rem_q  <= rem_q - (WADDR_W+1)'(1);
            if (rem_q == (WADDR_W+1)'(1)) begin
              state_q     <= DONE;
              wr_ready_q  <= 1'b0;
              load_busy_q <= 1'b0;
              load_done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          wr_ready_q  <= 1'b0;
          load_busy_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar b = 0; b < MEM_TO_CMD; b++) begin : g_bank
    cmd_mem_bank #(
      .AW(CMD_ADDR_WIDTH),
      .DW(MEM_WIDTH)
    ) u_bank (
      .clk     (clk),
      .rst_n   (reset_n),
      .we_i    (accept && (wsel == SEL_W'(b))),
      .waddr_i (wrow),
      .wdata_i (bus.wr_data),
      .raddr_i (bus.instr_ptr),
      .rdata_o (rd_cat[MEM_WIDTH*b +: MEM_WIDTH])
    );
  end

`ifdef CMD_MEM_OUTREG_EN
  logic [CMD_WIDTH-1:0] cmd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q <= '0;
    end else begin
      cmd_q <= rd_cat;
    end
  end

  assign bus.cmd_read = cmd_q;
`else
  assign bus.cmd_read = rd_cat;
`endif

  assign bus.wr_ready  = wr_ready_q;
  assign bus.load_busy = load_busy_q;
  assign bus.load_done = load_done_q;

endmodule
